gamma_calc: RTL

- Branch-metric (gamma) generation stage feeding the 8-state max-log-MAP forward/backward recursion stages.
- Accepts one soft symbol triple per trellis step: systematic ys, parity yp and a-priori la. Computes the four distinct branch metrics for rate-1/2 RSC (u,p) combinations.
- Writes each metric set to gamma memory at a sequential step address. Frames are bounded by a start pulse and a done pulse.

---
 rtl/gamma_calc_if.sv | 29 ++
 rtl/gamma_calc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gamma_calc_if.sv
// Symbol-in / metric-out bundle for the gamma branch-metric stage.
// The slave side is the gamma_calc block; the master side feeds symbols and takes metric writes.
interface gamma_calc_if #(
  parameter int IN_W   = 8,
  parameter int ADDR_W = 8,
  parameter int OUT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [IN_W-1:0]   ys;
  logic signed [IN_W-1:0]   yp;
  logic signed [IN_W-1:0]   la;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [OUT_W-1:0]  g_00;
  logic signed [OUT_W-1:0]  g_01;
  logic signed [OUT_W-1:0]  g_10;
  logic signed [OUT_W-1:0]  g_11;

  modport slave (
    input  in_valid, ys, yp, la,
    output in_ready, wr_en, wr_addr, g_00, g_01, g_10, g_11
  );

  modport master (
    output in_valid, ys, yp, la,
    input  in_ready, wr_en, wr_addr, g_00, g_01, g_10, g_11
  );
endinterface

// File: rtl/gamma_calc.sv
// Branch-metric (gamma) generator for the 8-state max-log-MAP recursions: one
// soft triple per trellis step in, four bipolar (u,p) metrics out to gamma memory.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | accepting symbols until FRAME_LEN have been taken
//   ST_FLUSH | no new symbols; draining the two-stage pipeline
//   ST_DONE  | one-cycle done pulse, busy already low
module gamma_calc #(
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8,
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  gamma_calc_if.slave   bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SW    = IN_W + 1;
  localparam int GW    = IN_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]         rem_q, rem_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     accept;
  logic                     rem_tc;

  logic                     v1_q, v1_d;
  logic signed [SW-1:0]     s1_q, s1_d;
  logic signed [IN_W-1:0]   yp1_q, yp1_d;
  logic [ADDR_W-1:0]        a1_q, a1_d;

  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic signed [OUT_W-1:0]  g00_q, g00_d;
  logic signed [OUT_W-1:0]  g01_q, g01_d;
  logic signed [OUT_W-1:0]  g10_q, g10_d;
  logic signed [OUT_W-1:0]  g11_q, g11_d;

  logic signed [GW-1:0]     s_x, yp_x;
  logic signed [GW-1:0]     g00_w, g01_w, g10_w, g11_w;

  // Remaining-accept down-counter; the last symbol is the one taken at count 1.
  assign rem_tc = (rem_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          rem_d   = CNT_W'(FRAME_LEN);
          addr_d  = '0;
        end
      end
      ST_RUN: begin
        accept = bus.in_valid;
        if (accept) begin
          rem_d  = rem_q - CNT_W'(1);
          addr_d = addr_q + ADDR_W'(1);
          if (rem_tc) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Once stage 1 is empty the final write is on the bus this cycle.
        if (!v1_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready = (state_q == ST_RUN);
  assign busy         = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done         = (state_q == ST_DONE);

  // Stage 1: systematic plus a-priori folded into one term.
  always_comb begin
    v1_d  = accept;
    s1_d  = s1_q;
    yp1_d = yp1_q;
    a1_d  = a1_q;
    if (accept) begin
      s1_d  = SW'(bus.ys) + SW'(bus.la);
      yp1_d = bus.yp;
      a1_d  = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= 1'b0;
      s1_q  <= '0;
      yp1_q <= '0;
      a1_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      s1_q  <= s1_d;
      yp1_q <= yp1_d;
      a1_q  <= a1_d;
    end
  end

  assign s_x   = GW'(s1_q);
  assign yp_x  = GW'(yp1_q);
  assign g00_w = -s_x - yp_x;
  assign g01_w = -s_x + yp_x;
  assign g10_w =  s_x - yp_x;
  assign g11_w =  s_x + yp_x;

  // Stage 2: metrics and address hold their last value across bubbles.
  always_comb begin
    wr_en_d   = v1_q;
    wr_addr_d = wr_addr_q;
    g00_d     = g00_q;
    g01_d     = g01_q;
    g10_d     = g10_q;
    g11_d     = g11_q;
    if (v1_q) begin
      wr_addr_d = a1_q;
      g00_d     = OUT_W'(g00_w);
      g01_d     = OUT_W'(g01_w);
      g10_d     = OUT_W'(g10_w);
      g11_d     = OUT_W'(g11_w);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      g00_q     <= '0;
      g01_q     <= '0;
      g10_q     <= '0;
      g11_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      g00_q     <= g00_d;
      g01_q     <= g01_d;
      g10_q     <= g10_d;
      g11_q     <= g11_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.g_00    = g00_q;
  assign bus.g_01    = g01_q;
  assign bus.g_10    = g10_q;
  assign bus.g_11    = g11_q;

endmodule
